seq_tx_reader: RTL

Read-back engine for the Needleman-Wunsch UART path. On a start pulse it reads sequence A and then sequence B out of the two sequence memories, each N bytes wide. It sends every byte to the UART transmitter with a tx_start/tx_done handshake and appends a separator byte after each sequence. It drives the same read addresses (addr_rA, addr_rB) that the RX address manager writes through, so it works as the TX-side counterpart of the receive path.

---
 rtl/nw_uart_pkg.sv | 19 +
 rtl/seq_byte_sel.sv | 33 +++
 rtl/seq_tx_reader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/nw_uart_pkg.sv
// Shared definitions for the Needleman-Wunsch UART path.
// Holds the read-back FSM state encoding, the separator byte and the
// character-count / character-width defaults shared with the RX side.
package nw_uart_pkg;

  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned W_DEFAULT = 8;
  localparam logic [7:0]  SEP_BYTE  = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_FIN
  } tx_state_t;

endpackage

// File: rtl/seq_byte_sel.sv
// Maps a stream byte index k to its source.
// Ports:
//   k      in   stream byte index, 0..2N+1
//   sel_b  out  byte comes from sequence B (k > N)
//   idx    out  address within the selected sequence, 0..N-1 (0 for separators)
//   is_sep out  byte is a separator (k == N or k == 2N+1)
module seq_byte_sel
  import nw_uart_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int KW   = $clog2(2 * N + 2),
  parameter int ADDR = $clog2(N + 1)
) (
  input  logic [KW-1:0]   k,
  output logic            sel_b,
  output logic [ADDR-1:0] idx,
  output logic            is_sep
);

  localparam logic [KW-1:0] K_SEP_A = KW'(N);
  localparam logic [KW-1:0] K_B0    = KW'(N + 1);
  localparam logic [KW-1:0] K_SEP_B = KW'(2 * N + 1);

  always_comb begin
    sel_b  = (k > K_SEP_A);
    is_sep = (k == K_SEP_A) || (k == K_SEP_B);
    idx    = '0;
    if (!is_sep) begin
      idx = sel_b ? ADDR'(k - K_B0) : ADDR'(k);
    end
  end

endmodule

// File: rtl/seq_tx_reader.sv
// Read-back engine: on start, streams sequence A, a separator, sequence B
// and a final separator to the UART transmitter, one byte per
// tx_start/tx_done handshake.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            single-cycle dump request (accepted only when idle)
//   dout_A, dout_B   memory read data, valid one cycle after re_A / re_B
//   tx_done          TX finished current byte (only observed while waiting)
//   addr_rA, addr_rB memory read addresses (hold outside fetch)
//   re_A, re_B       memory read enables
//   tx_data          byte to transmit
//   tx_start         one-cycle transmit request
//   busy             stream in progress
//   done             one-cycle completion pulse
module seq_tx_reader
  import nw_uart_pkg::*;
#(
  parameter int         N    = N_DEFAULT,
  parameter int         ADDR = $clog2(N + 1),
  parameter int         W    = W_DEFAULT,
  parameter logic [7:0] SEP  = SEP_BYTE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    dout_A,
  input  logic [W-1:0]    dout_B,
  input  logic            tx_done,
  output logic [ADDR-1:0] addr_rA,
  output logic [ADDR-1:0] addr_rB,
  output logic            re_A,
  output logic            re_B,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  output logic            busy,
  output logic            done
);

  localparam int            KW     = $clog2(2 * N + 2);
  localparam logic [KW-1:0] K_LAST = KW'(2 * N + 1);

  tx_state_t       state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_nxt;
  logic            advance;
  logic            nxt_sel_b;
  logic            nxt_is_sep;
  logic [ADDR-1:0] nxt_idx;
  logic            sel_b_q;
  logic            is_sep_q;

  // Read enables are registered, so the source of the *next* byte must be
  // known while still in IDLE/WAIT; the selector looks at k_nxt for that.
  always_comb begin
    k_nxt   = (state == S_IDLE) ? '0 : k + KW'(1);
    advance = ((state == S_IDLE) && start) ||
              ((state == S_WAIT) && tx_done && (k != K_LAST));
  end

  seq_byte_sel #(
    .N    (N),
    .KW   (KW),
    .ADDR (ADDR)
  ) u_byte_sel (
    .k      (k_nxt),
    .sel_b  (nxt_sel_b),
    .idx    (nxt_idx),
    .is_sep (nxt_is_sep)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      k        <= '0;
      addr_rA  <= '0;
      addr_rB  <= '0;
      re_A     <= 1'b0;
      re_B     <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sel_b_q  <= 1'b0;
      is_sep_q <= 1'b0;
    end else begin
      re_A     <= 1'b0;
      re_B     <= 1'b0;
      tx_start <= 1'b0;
      done     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) busy <= 1'b1;
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          tx_data  <= is_sep_q ? SEP : (sel_b_q ? 8'(dout_B) : 8'(dout_A));
          tx_start <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: state <= S_WAIT;
        S_WAIT: begin
          if (tx_done && (k == K_LAST)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Shared entry into the next byte from IDLE (k=0) or WAIT (k+1);
      // separators skip the memory fetch.
      if (advance) begin
        k        <= k_nxt;
        sel_b_q  <= nxt_sel_b;
        is_sep_q <= nxt_is_sep;
        if (nxt_is_sep) begin
          state <= S_LOAD;
        end else begin
          state <= S_FETCH;
          if (nxt_sel_b) begin
            re_B    <= 1'b1;
            addr_rB <= nxt_idx;
          end else begin
            re_A    <= 1'b1;
            addr_rA <= nxt_idx;
          end
        end
      end
    end
  end

endmodule
